btn_press_cnt: RTL and testbench

//  Input-side counterpart of the LED counter path: reads a raw board push-button and turns it into clean events.

---
 rtl/btn_press_cnt.sv | 76 +++++++
 tb/tb_btn_press_cnt.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/btn_press_cnt.sv
// Push-button front end: two-stage synchroniser, debouncer, press/release pulses,
// and a press counter that either wraps or locks at a runtime limit.
module btn_press_cnt #(
  parameter int WIDTH      = 4,
  parameter int DEBOUNCE   = 16,
  parameter int ACTIVE_LOW = 1,
  parameter int FREERUN    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic [WIDTH-1:0] top,
  input  logic             clr,
  output logic             btn_state,
  output logic             pressed,
  output logic             released,
  output logic [WIDTH-1:0] count,
  output logic             full
);

  localparam int            DW       = $clog2(DEBOUNCE) + 1;
  localparam logic [DW-1:0] DLAST    = DW'(DEBOUNCE - 1);
  localparam logic          IDLE_LVL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [1:0]    sync;
  logic          s;
  logic [DW-1:0] dcnt;
  logic          accept;
  logic          press_now;

  // s is the synchronised level normalised so that 1 always means pressed.
  assign s         = (ACTIVE_LOW != 0) ? ~sync[1] : sync[1];
  assign accept    = (s != btn_state) && (dcnt == DLAST);
  assign press_now = accept && s;

  // NOTE: reset is synchronous here, so it lives inside the clocked branch and
  // the synchroniser restarts from the idle pin level, not from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= {2{IDLE_LVL}};
      dcnt      <= '0;
      btn_state <= 1'b0;
      pressed   <= 1'b0;
      released  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      sync     <= {sync[0], btn_raw};
      pressed  <= 1'b0;
      released <= 1'b0;
      if (s == btn_state) begin
        dcnt <= '0;
      end else if (accept) begin
        btn_state <= s;
        dcnt      <= '0;
        pressed   <= s;
        released  <= ~s;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  // Limit compare is unsigned; a lowered top leaves count above it, which
  // counts as "at the limit" and either wraps or holds.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (press_now) begin
      if (count < top)       count <= count + 1'b1;
      else if (FREERUN != 0) count <= '0;
    end
  end

  assign full = (count >= top);

endmodule

// File: tb/tb_btn_press_cnt.sv
// Bench for btn_press_cnt: three instances (wrap, lock, single-cycle debounce) share
// stimulus; a run-length model is checked every cycle, plus literal timing checks.
module tb_btn_press_cnt;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_raw = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] top = 4'd5;

  logic [2:0] st, pr, rl, fl;
  logic [3:0] cv [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_press_cnt #(.WIDTH(4), .DEBOUNCE(4), .ACTIVE_LOW(1), .FREERUN(1)) u_free (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .top(top), .clr(clr),
    .btn_state(st[0]), .pressed(pr[0]), .released(rl[0]), .count(cv[0]), .full(fl[0]));

  btn_press_cnt #(.WIDTH(4), .DEBOUNCE(4), .ACTIVE_LOW(1), .FREERUN(0)) u_lock (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .top(top), .clr(clr),
    .btn_state(st[1]), .pressed(pr[1]), .released(rl[1]), .count(cv[1]), .full(fl[1]));

  btn_press_cnt #(.WIDTH(4), .DEBOUNCE(1), .ACTIVE_LOW(1), .FREERUN(1)) u_d1 (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .top(top), .clr(clr),
    .btn_state(st[2]), .pressed(pr[2]), .released(rl[2]), .count(cv[2]), .full(fl[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the pressed-level the debouncer sees lags the pin by two edges; a level
  // is accepted once it has differed from the debounced state on D edges in a row.
  int D  [3] = '{4, 4, 1};
  bit FR [3] = '{1'b1, 1'b0, 1'b1};
  bit m_h0 = 1'b0, m_h1 = 1'b0, m_s;
  bit m_st [3] = '{0, 0, 0};
  bit m_pr [3] = '{0, 0, 0};
  bit m_rl [3] = '{0, 0, 0};
  int m_run [3] = '{0, 0, 0};
  int m_cnt [3] = '{0, 0, 0};

  always @(posedge clk) begin
    m_s = m_h1;
    if (rst) begin
      m_h0 = 1'b0;
      m_h1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_st[i] = 1'b0; m_pr[i] = 1'b0; m_rl[i] = 1'b0; m_run[i] = 0; m_cnt[i] = 0;
      end
    end else begin
      m_h1 = m_h0;
      m_h0 = ~btn_raw;
      for (int i = 0; i < 3; i++) begin
        m_pr[i] = 1'b0;
        m_rl[i] = 1'b0;
        if (m_s != m_st[i]) begin
          m_run[i]++;
          if (m_run[i] == D[i]) begin
            m_st[i] = m_s; m_run[i] = 0; m_pr[i] = m_s; m_rl[i] = !m_s;
          end
        end else begin
          m_run[i] = 0;
        end
        if (clr)                   m_cnt[i] = 0;
        else if (m_pr[i]) begin
          if (m_cnt[i] < int'(top)) m_cnt[i]++;
          else if (FR[i])           m_cnt[i] = 0;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("state%0d", i),    st[i], m_st[i]);
      check($sformatf("pressed%0d", i),  pr[i], m_pr[i]);
      check($sformatf("released%0d", i), rl[i], m_rl[i]);
      check($sformatf("count%0d", i),    cv[i], m_cnt[i]);
      check($sformatf("full%0d", i),     fl[i], (m_cnt[i] >= int'(top)));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_release();
    @(negedge clk) btn_raw = 1'b0;
    cyc(8);
    @(negedge clk) btn_raw = 1'b1;
    cyc(8);
  endtask

  int fe [5] = '{1, 2, 3, 0, 1};
  int le [5] = '{1, 2, 3, 3, 3};

  initial begin
    cyc(3);
    check("rst_state", st[0], 1'b0);
    check("rst_count", cv[0], 4'd0);
    check("rst_full_top5", fl[0], 1'b0);
    @(negedge clk) top = 4'd0;
    cyc(1);
    check("rst_full_top0", fl[0], 1'b1);
    @(negedge clk) begin top = 4'd5; rst = 1'b0; end
    cyc(3);

    // Clean press: D=1 accepts at edge 3, D=4 at edge 6.
    @(negedge clk) btn_raw = 1'b0;
    cyc(3);
    check("d1_press_edge3", pr[2], 1'b1);
    check("d4_no_press_edge3", pr[0], 1'b0);
    cyc(2);
    check("press_edge5_state", st[0], 1'b0);
    cyc(1);
    check("press_edge6_state", st[0], 1'b1);
    check("press_edge6_pulse", pr[0], 1'b1);
    check("press_edge6_count", cv[0], 4'd1);
    cyc(1);
    check("press_pulse_one_cycle", pr[0], 1'b0);
    cyc(4);
    @(negedge clk) btn_raw = 1'b1;
    cyc(5);
    check("rel_edge5_pulse", rl[0], 1'b0);
    cyc(1);
    check("rel_edge6_pulse", rl[0], 1'b1);
    check("rel_edge6_state", st[0], 1'b0);
    check("rel_count_kept", cv[0], 4'd1);
    cyc(4);

    // Glitches of three low cycles never reach the D=4 threshold.
    repeat (5) begin
      @(negedge clk) btn_raw = 1'b0;
      cyc(3);
      @(negedge clk) btn_raw = 1'b1;
      cyc(3);
    end
    cyc(4);
    check("glitch_state", st[0], 1'b0);
    check("glitch_count", cv[0], 4'd1);

    // Wrap versus lock at top=3.
    @(negedge clk) begin top = 4'd3; clr = 1'b1; end
    @(negedge clk) clr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      press_release();
      check($sformatf("free_count_p%0d", k), cv[0], fe[k]);
      check($sformatf("lock_count_p%0d", k), cv[1], le[k]);
      check($sformatf("free_full_p%0d", k),  fl[0], (fe[k] == 3));
      check($sformatf("lock_full_p%0d", k),  fl[1], (k >= 2));
    end
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    check("lock_clr_count", cv[1], 4'd0);
    check("lock_clr_full", fl[1], 1'b0);

    // Clear on the accepting edge wins over the increment.
    @(negedge clk) top = 4'd5;
    press_release();
    press_release();
    check("pre_clr_count", cv[0], 4'd2);
    @(negedge clk) btn_raw = 1'b0;
    cyc(5);
    @(negedge clk) clr = 1'b1;
    cyc(1);
    check("clr_edge_pulse", pr[0], 1'b1);
    check("clr_edge_count", cv[0], 4'd0);
    @(negedge clk) clr = 1'b0;
    cyc(4);
    @(negedge clk) btn_raw = 1'b1;
    cyc(8);

    // Lowering top below count: lock holds, wrap clears.
    press_release();
    press_release();
    @(negedge clk) top = 4'd1;
    press_release();
    check("lowered_top_lock", cv[1], 4'd2);
    check("lowered_top_free", cv[0], 4'd0);
    check("lowered_top_full", fl[1], 1'b1);

    // Reset mid-debounce, button still held through reset release.
    @(negedge clk) btn_raw = 1'b0;
    cyc(4);
    @(negedge clk) rst = 1'b1;
    cyc(2);
    check("midrst_state", st[0], 1'b0);
    check("midrst_count", cv[1], 4'd0);
    @(negedge clk) rst = 1'b0;
    cyc(5);
    check("postrst_edge5", pr[0], 1'b0);
    cyc(1);
    check("postrst_edge6_pulse", pr[0], 1'b1);
    check("postrst_edge6_count", cv[0], 4'd1);
    @(negedge clk) btn_raw = 1'b1;
    cyc(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
